// File: rtl/prim_rec_ctrl.sv
// Primitive-recursion controller: f(x,0)=g(x), f(x,k+1)=h(x,k,f(x,k)).
// Sequences external g/h operation blocks over a start/ready handshake.
module prim_rec_ctrl #(
  parameter int BW    = 16,
  parameter int ICNT  = 2,
  parameter int SEL   = 1,
  parameter int MAXIT = 65535
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ST,
  input  logic [ICNT*BW-1:0] IN,
  output logic             RD,
  output logic [BW-1:0]    RES,
  output logic             ERR,
  output logic             G_ST,
  input  logic             G_RD,
  input  logic [BW-1:0]    G_RES,
  output logic             H_ST,
  input  logic             H_RD,
  input  logic [BW-1:0]    H_RES,
  output logic [ICNT*BW-1:0] ARGS,
  output logic [BW-1:0]    K,
  output logic [BW-1:0]    ACC
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GST,
    S_GWT,
    S_HST,
    S_HWT,
    S_DONE
  } state_t;

  localparam logic [BW:0] MAXW = (BW+1)'(MAXIT);

  state_t            state_q, state_d;
  logic              rd_q, rd_d;
  logic [BW-1:0]     res_q, res_d;
  logic              err_q, err_d;
  logic              g_st_q, g_st_d;
  logic              h_st_q, h_st_d;
  logic [BW-1:0]     k_q, k_d;
  logic [BW-1:0]     acc_q, acc_d;
  logic [ICNT*BW-1:0] args_q, args_d;
  logic [BW-1:0]     n_q, n_d;
  logic              st_old_q;
  logic              g_rd_old_q;
  logic              h_rd_old_q;
  logic              g_arm_q, g_arm_d;
  logic              h_arm_q, h_arm_d;

  logic              st_rise;
  logic              g_done;
  logic              h_done;
  logic [BW-1:0]     in_n;
  logic [BW-1:0]     k_inc;

  assign st_rise = ST & ~st_old_q;
  // A child is done only on a ready rise after it was seen busy.
  assign g_done  = g_arm_q & G_RD & ~g_rd_old_q;
  assign h_done  = h_arm_q & H_RD & ~h_rd_old_q;
  assign in_n    = IN[SEL*BW +: BW];
  assign k_inc   = k_q + BW'(1);

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    res_d   = res_q;
    err_d   = err_q;
    k_d     = k_q;
    acc_d   = acc_q;
    args_d  = args_q;
    n_d     = n_q;
    g_arm_d = g_arm_q;
    h_arm_d = h_arm_q;
    unique case (state_q)
      S_IDLE: begin
        if (st_rise) begin
          args_d = IN;
          n_d    = in_n;
          err_d  = 1'b0;
          if ({1'b0, in_n} > MAXW) begin
            err_d = 1'b1;
            res_d = '0;
          end else begin
            rd_d    = 1'b0;
            k_d     = '0;
            state_d = S_GST;
          end
        end
      end
      S_GST: begin
        g_arm_d = 1'b0;
        state_d = S_GWT;
      end
      S_GWT: begin
        if (!G_RD) g_arm_d = 1'b1;
        if (g_done) begin
          acc_d   = G_RES;
          state_d = (n_q == '0) ? S_DONE : S_HST;
        end
      end
      S_HST: begin
        h_arm_d = 1'b0;
        state_d = S_HWT;
      end
      S_HWT: begin
        if (!H_RD) h_arm_d = 1'b1;
        if (h_done) begin
          acc_d   = H_RES;
          k_d     = k_inc;
          state_d = (k_inc == n_q) ? S_DONE : S_HST;
        end
      end
      S_DONE: begin
        res_d   = acc_q;
        rd_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    g_st_d = (state_d == S_GST);
    h_st_d = (state_d == S_HST);
  end

  // State, registered outputs and edge-detect history.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      rd_q       <= 1'b1;
      res_q      <= '0;
      err_q      <= 1'b0;
      g_st_q     <= 1'b0;
      h_st_q     <= 1'b0;
      k_q        <= '0;
      acc_q      <= '0;
      args_q     <= '0;
      n_q        <= '0;
      st_old_q   <= 1'b0;
      g_rd_old_q <= 1'b0;
      h_rd_old_q <= 1'b0;
      g_arm_q    <= 1'b0;
      h_arm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      res_q      <= res_d;
      err_q      <= err_d;
      g_st_q     <= g_st_d;
      h_st_q     <= h_st_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      args_q     <= args_d;
      n_q        <= n_d;
      st_old_q   <= ST;
      g_rd_old_q <= G_RD;
      h_rd_old_q <= H_RD;
      g_arm_q    <= g_arm_d;
      h_arm_q    <= h_arm_d;
    end
  end

  assign RD   = rd_q;
  assign RES  = res_q;
  assign ERR  = err_q;
  assign G_ST = g_st_q;
  assign H_ST = h_st_q;
  assign ARGS = args_q;
  assign K    = k_q;
  assign ACC  = acc_q;

endmodule

// File: tb/tb_prim_rec_ctrl.sv
// Bench for prim_rec_ctrl: g returns x0, h returns acc+x0,
// both with 3-cycle latency; results checked via a scoreboard queue.
module tb_prim_rec_ctrl;

  localparam int BW = 16;
  localparam int ICNT = 2;

  logic          CLK = 0;
  logic          RST = 0;
  logic          ST = 0;
  logic [31:0]   IN = '0;
  logic          RD;
  logic [15:0]   RES;
  logic          ERR;
  logic          G_ST;
  logic          G_RD;
  logic [15:0]   G_RES;
  logic          H_ST;
  logic          H_RD;
  logic [15:0]   H_RES;
  logic [31:0]   ARGS;
  logic [15:0]   K;
  logic [15:0]   ACC;

  int checks = 0;
  int failures = 0;
  int gcnt = 0;
  int hcnt = 0;

  logic [15:0] exp_q[$];

  // child models
  logic       g_rd_m = 1;
  logic       h_rd_m = 1;
  logic       g_glitch = 0;
  int         gc = 0;
  int         hc = 0;
  logic [15:0] g_res_m = '0;
  logic [15:0] h_res_m = '0;

  assign G_RD  = g_rd_m & ~g_glitch;
  assign H_RD  = h_rd_m;
  assign G_RES = g_res_m;
  assign H_RES = h_res_m;

  prim_rec_ctrl #(
    .BW(BW), .ICNT(ICNT), .SEL(1), .MAXIT(255)
  ) dut (
    .CLK(CLK), .RST(RST), .ST(ST), .IN(IN),
    .RD(RD), .RES(RES), .ERR(ERR),
    .G_ST(G_ST), .G_RD(G_RD), .G_RES(G_RES),
    .H_ST(H_ST), .H_RD(H_RD), .H_RES(H_RES),
    .ARGS(ARGS), .K(K), .ACC(ACC)
  );

  always #5 CLK = ~CLK;

  // g: ready stays high one cycle after start, then low, rises 3 cycles after start
  always @(posedge CLK) begin
    if (G_ST) begin
      gc <= 3;
      g_res_m <= ARGS[15:0];
    end else if (gc != 0) begin
      gc <= gc - 1;
      g_rd_m <= (gc == 1);
    end
  end

  always @(posedge CLK) begin
    if (H_ST) begin
      hc <= 3;
      h_res_m <= ACC + ARGS[15:0];
    end else if (hc != 0) begin
      hc <= hc - 1;
      h_rd_m <= (hc == 1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // pulse monitor: counts child starts, checks K and exclusivity
  always @(negedge CLK) begin
    if (G_ST || H_ST) chk("gh_excl", {31'b0, G_ST & H_ST}, 0);
    if (G_ST) gcnt = gcnt + 1;
    if (H_ST) begin
      chk("k_val", {16'b0, K}, hcnt);
      hcnt = hcnt + 1;
    end
  end

  task automatic pulse_st(input logic [15:0] x0, input logic [15:0] n);
    @(negedge CLK);
    IN = {n, x0};
    ST = 1;
    @(negedge CLK);
    ST = 0;
  endtask

  task automatic run(input logic [15:0] x0, input logic [15:0] n,
                     input logic [15:0] exp_res, input bit disturb);
    bit done = 0;
    bit dist_done = 0;
    logic [15:0] e;
    gcnt = 0;
    hcnt = 0;
    exp_q.push_back(exp_res);
    pulse_st(x0, n);
    chk("rd_busy", {31'b0, RD}, 0);
    for (int i = 0; i < 20000 && !done; i++) begin
      if (disturb && !dist_done && hcnt == 2) begin
        dist_done = 1;
        ST = 1;
        g_glitch = 1;
        @(negedge CLK);
        ST = 0;
        @(negedge CLK);
        ST = 1;
        g_glitch = 0;
        @(negedge CLK);
        ST = 0;
      end
      if (RD) done = 1;
      else @(negedge CLK);
    end
    chk("rd_timeout", {31'b0, done}, 1);
    e = exp_q.pop_front();
    chk("res", {16'b0, RES}, {16'b0, e});
    chk("err", {31'b0, ERR}, 0);
    chk("g_pulses", gcnt, 1);
    chk("h_pulses", hcnt, {16'b0, n});
    chk("args", ARGS, {n, x0});
  endtask

  task automatic reject(input logic [15:0] x0, input logic [15:0] n);
    bit dropped = 0;
    logic [15:0] e;
    gcnt = 0;
    hcnt = 0;
    exp_q.push_back(16'h0);
    pulse_st(x0, n);
    for (int i = 0; i < 10; i++) begin
      if (!RD) dropped = 1;
      @(negedge CLK);
    end
    e = exp_q.pop_front();
    chk("rej_rd", {31'b0, dropped}, 0);
    chk("rej_err", {31'b0, ERR}, 1);
    chk("rej_res", {16'b0, RES}, {16'b0, e});
    chk("rej_g", gcnt, 0);
  endtask

  initial begin
    bit hit = 0;
    RST = 1;
    #1;
    chk("rst_rd", {31'b0, RD}, 1);
    chk("rst_res", {16'b0, RES}, 0);
    chk("rst_err", {31'b0, ERR}, 0);
    chk("rst_gst", {31'b0, G_ST}, 0);
    chk("rst_hst", {31'b0, H_ST}, 0);
    chk("rst_k", {16'b0, K}, 0);
    chk("rst_acc", {16'b0, ACC}, 0);
    chk("rst_args", ARGS, 0);
    repeat (2) @(negedge CLK);
    RST = 0;
    repeat (2) @(negedge CLK);

    run(16'd5, 16'd3, 16'd20, 0);
    run(16'd7, 16'd0, 16'd7, 0);
    run(16'h8000, 16'd1, 16'h0000, 0);
    reject(16'd4, 16'd300);
    run(16'd4, 16'd2, 16'd12, 0);
    reject(16'd1, 16'd256);
    run(16'd1, 16'd255, 16'd256, 0);

    // abort mid-run during the 4th h wait
    gcnt = 0;
    hcnt = 0;
    pulse_st(16'd5, 16'd10);
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (hcnt >= 4) hit = 1;
      else @(negedge CLK);
    end
    chk("abort_reach", {31'b0, hit}, 1);
    @(negedge CLK);
    RST = 1;
    #1;
    chk("abort_rd", {31'b0, RD}, 1);
    chk("abort_res", {16'b0, RES}, 0);
    chk("abort_gst", {31'b0, G_ST | H_ST}, 0);
    @(negedge CLK);
    RST = 0;
    gcnt = 0;
    hcnt = 0;
    repeat (20) @(negedge CLK);
    chk("abort_quiet", gcnt + hcnt, 0);
    run(16'd5, 16'd1, 16'd10, 0);

    run(16'd5, 16'd3, 16'd20, 1);

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
